// File: rtl/id_inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_inst_queue: in-order fetch->decode return queue with flush drop count |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_inst_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int ORDER_W = 64,
  parameter logic [ILEN-1:0] NOP_INST = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_flush,
  input  logic                       i_req,
  input  logic [XLEN-1:0]            i_req_pc,
  input  logic [XLEN-1:0]            i_req_pc_next,
  output logic                       o_req_ok,
  input  logic                       imem_resp,
  input  logic [ILEN-1:0]            imem_rdata,
  input  logic                       i_ready,
  output logic                       o_valid,
  output logic [ILEN-1:0]            o_inst,
  output logic [XLEN-1:0]            o_pc,
  output logic [XLEN-1:0]            o_pc_next,
  output logic [ORDER_W-1:0]         o_order,
  output logic                       o_imem_stall,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int DW = CW + 4;

  logic [XLEN-1:0]    r_pc      [DEPTH];
  logic [XLEN-1:0]    r_pc_next [DEPTH];
  logic [ILEN-1:0]    r_data    [DEPTH];
  logic [DEPTH-1:0]   r_filled;
  logic [PW-1:0]      r_head, r_fill, r_tail;
  logic [CW-1:0]      r_count, r_pending;
  logic [DW-1:0]      r_drop;
  logic [ORDER_W-1:0] r_order;

  logic          w_head_filled, w_fill_ok, w_bypass, w_pop, w_alloc;
  logic [DW-1:0] w_drop_sum;

  always_comb begin
    w_head_filled = r_filled[r_head];
    w_fill_ok     = imem_resp && (r_drop == '0) && (r_pending != '0);
    // Head entry is the one awaiting this response: forward it directly.
    w_bypass      = !w_head_filled && (r_fill == r_head) && (r_count != '0) && w_fill_ok;
    o_valid       = (w_head_filled || w_bypass) && !i_flush;
    o_req_ok      = (r_count < CW'(DEPTH)) && !i_flush;
    w_pop         = o_valid && i_ready;
    w_alloc       = i_req && o_req_ok;
    o_inst        = !o_valid ? NOP_INST : (w_head_filled ? r_data[r_head] : imem_rdata);
    o_pc          = r_pc[r_head];
    o_pc_next     = r_pc_next[r_head];
    o_order       = r_order;
    o_count       = r_count;
    o_imem_stall  = (r_count != '0) && !o_valid;
    w_drop_sum    = r_drop + DW'(r_pending);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]      <= '0;
        r_pc_next[i] <= '0;
        r_data[i]    <= '0;
      end
      r_filled  <= '0;
      r_head    <= '0;
      r_fill    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      r_drop    <= '0;
      r_order   <= '0;
    end else if (i_flush) begin
      r_filled  <= '0;
      r_head    <= '0;
      r_fill    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_pending <= '0;
      // A response arriving now belongs to one of the squashed requests.
      if (imem_resp && (w_drop_sum != '0))
        r_drop <= w_drop_sum - DW'(1);
      else
        r_drop <= w_drop_sum;
    end else begin
      if (w_pop) begin
        r_filled[r_head] <= 1'b0;
        r_head           <= r_head + PW'(1);
        r_order          <= r_order + ORDER_W'(1);
      end
      if (imem_resp) begin
        if (r_drop != '0) begin
          r_drop <= r_drop - DW'(1);
        end else if (r_pending != '0) begin
          r_data[r_fill]   <= imem_rdata;
          r_filled[r_fill] <= !(w_bypass && w_pop);
          r_fill           <= r_fill + PW'(1);
        end
      end
      if (w_alloc) begin
        r_pc[r_tail]      <= i_req_pc;
        r_pc_next[r_tail] <= i_req_pc_next;
        r_filled[r_tail]  <= 1'b0;
        r_tail            <= r_tail + PW'(1);
      end
      r_count   <= r_count + CW'(w_alloc) - CW'(w_pop);
      r_pending <= r_pending + CW'(w_alloc) - CW'(w_fill_ok);
    end
  end

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
    !(imem_resp && !i_flush && (r_drop == '0) && (r_pending == '0)));

endmodule
`default_nettype wire

// File: tb/tb_id_inst_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_inst_queue: vector table plus scoreboard checks for id_inst_queue  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_id_inst_queue;
  localparam logic [31:0] NOP = 32'h00000013;

  logic clk, rst, i_flush, i_req, o_req_ok, imem_resp, i_ready, o_valid, o_imem_stall;
  logic [31:0] i_req_pc, i_req_pc_next, imem_rdata, o_inst, o_pc, o_pc_next;
  logic [63:0] o_order;
  logic [2:0]  o_count;

  id_inst_queue dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_req(i_req), .i_req_pc(i_req_pc),
    .i_req_pc_next(i_req_pc_next), .o_req_ok(o_req_ok), .imem_resp(imem_resp),
    .imem_rdata(imem_rdata), .i_ready(i_ready), .o_valid(o_valid), .o_inst(o_inst),
    .o_pc(o_pc), .o_pc_next(o_pc_next), .o_order(o_order), .o_imem_stall(o_imem_stall),
    .o_count(o_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        req;
    logic [31:0] pc;
    logic        resp;
    logic [31:0] rdata;
    logic        ready;
    logic        flush;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic [2:0]  e_count;
    logic        e_req_ok;
    logic        e_stall;
    logic [63:0] e_order;
  } vec_t;
  vec_t tbl[10];

  typedef struct { logic [31:0] pc; bit filled; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] pc; bit live; } mreq_t;
  ent_t  sb_q[$];
  mreq_t mem_q[$];
  logic [63:0] m_order;
  logic [31:0] next_pc;

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return (pc << 8) + 32'h0000_0013;
  endfunction

  task automatic drive(input bit req, input logic [31:0] pc, input bit resp,
                       input logic [31:0] rd, input bit ready, input bit flush);
    i_req = req; i_req_pc = pc; i_req_pc_next = pc + 32'd4;
    imem_resp = resp; imem_rdata = rd; i_ready = ready; i_flush = flush;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete(); mem_q.delete(); m_order = 0; next_pc = 0;
    #4;
    chk("rst_valid", 64'(o_valid), 0);
    chk("rst_inst", 64'(o_inst), 64'(NOP));
    chk("rst_pc", 64'(o_pc), 0);
    chk("rst_pc_next", 64'(o_pc_next), 0);
    chk("rst_order", o_order, 0);
    chk("rst_count", 64'(o_count), 0);
    chk("rst_stall", 64'(o_imem_stall), 0);
    chk("rst_req_ok", 64'(o_req_ok), 1);
    @(posedge clk); #1;
  endtask

  // One cycle against the reference model: requests/responses/pops/flush.
  task automatic sb_cycle(input bit req, input bit resp_in, input bit ready, input bit flush);
    bit acc, live, resp, exp_valid;
    logic [31:0] rd, exp_inst;
    resp = resp_in && (mem_q.size() != 0);
    live = 1'b0; rd = '0;
    if (resp) begin
      live = mem_q[0].live;
      rd   = word_of(mem_q[0].pc);
    end
    acc = req && (sb_q.size() < 4) && !flush;
    exp_valid = !flush && (sb_q.size() != 0) && (sb_q[0].filled || live);
    exp_inst  = !exp_valid ? NOP : (sb_q[0].filled ? sb_q[0].data : rd);
    drive(req, next_pc, resp, rd, ready, flush);
    #4;
    chk("sb_valid", 64'(o_valid), 64'(exp_valid));
    chk("sb_inst", 64'(o_inst), 64'(exp_inst));
    chk("sb_count", 64'(o_count), 64'(sb_q.size()));
    chk("sb_req_ok", 64'(o_req_ok), 64'((sb_q.size() < 4) && !flush));
    chk("sb_stall", 64'(o_imem_stall), 64'((sb_q.size() != 0) && !exp_valid));
    chk("sb_order", o_order, m_order);
    if (exp_valid) begin
      chk("sb_pc", 64'(o_pc), 64'(sb_q[0].pc));
      chk("sb_pc_next", 64'(o_pc_next), 64'(sb_q[0].pc + 32'd4));
    end
    if (resp) void'(mem_q.pop_front());
    if (flush) begin
      sb_q.delete();
      for (int i = 0; i < mem_q.size(); i++) mem_q[i].live = 1'b0;
    end else begin
      if (live) begin
        for (int i = 0; i < sb_q.size(); i++)
          if (!sb_q[i].filled) begin
            sb_q[i].filled = 1'b1; sb_q[i].data = rd;
            break;
          end
      end
      if (exp_valid && ready) begin
        void'(sb_q.pop_front());
        m_order++;
      end
    end
    if (acc) begin
      sb_q.push_back('{next_pc, 1'b0, 32'h0});
      mem_q.push_back('{next_pc, 1'b1});
      next_pc += 32'd4;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    do_reset();

    // req  pc          resp rdata        rdy fl  valid inst         pc          cnt ok stall order
    tbl[0] = '{1, 32'h100, 0, 32'h0,        1, 0, 0, NOP,          32'h0,   0, 1, 0, 0};
    tbl[1] = '{0, 32'h0,   1, 32'h00A00093, 1, 0, 1, 32'h00A00093, 32'h100, 1, 1, 0, 0};
    tbl[2] = '{0, 32'h0,   0, 32'h0,        1, 0, 0, NOP,          32'h0,   0, 1, 0, 1};
    tbl[3] = '{1, 32'h200, 0, 32'h0,        1, 0, 0, NOP,          32'h0,   0, 1, 0, 1};
    tbl[4] = '{1, 32'h204, 0, 32'h0,        1, 0, 0, NOP,          32'h0,   1, 1, 1, 1};
    tbl[5] = '{0, 32'h0,   1, 32'h11111111, 1, 1, 0, NOP,          32'h0,   2, 0, 1, 1};
    tbl[6] = '{0, 32'h0,   1, 32'h22222222, 1, 0, 0, NOP,          32'h0,   0, 1, 0, 1};
    tbl[7] = '{1, 32'h300, 0, 32'h0,        1, 0, 0, NOP,          32'h0,   0, 1, 0, 1};
    tbl[8] = '{0, 32'h0,   1, 32'h33333333, 1, 0, 1, 32'h33333333, 32'h300, 1, 1, 0, 1};
    tbl[9] = '{0, 32'h0,   0, 32'h0,        1, 0, 0, NOP,          32'h0,   0, 1, 0, 2};
    for (int v = 0; v < 10; v++) begin
      drive(tbl[v].req, tbl[v].pc, tbl[v].resp, tbl[v].rdata, tbl[v].ready, tbl[v].flush);
      #4;
      chk($sformatf("v%0d_valid", v), 64'(o_valid), 64'(tbl[v].e_valid));
      chk($sformatf("v%0d_inst", v), 64'(o_inst), 64'(tbl[v].e_inst));
      chk($sformatf("v%0d_count", v), 64'(o_count), 64'(tbl[v].e_count));
      chk($sformatf("v%0d_req_ok", v), 64'(o_req_ok), 64'(tbl[v].e_req_ok));
      chk($sformatf("v%0d_stall", v), 64'(o_imem_stall), 64'(tbl[v].e_stall));
      chk($sformatf("v%0d_order", v), o_order, tbl[v].e_order);
      if (tbl[v].e_valid) chk($sformatf("v%0d_pc", v), 64'(o_pc), 64'(tbl[v].e_pc));
      @(posedge clk); #1;
    end

    // Fill to full while decode stalls, then drain.
    do_reset();
    sb_cycle(1, 0, 0, 0);
    repeat (3) sb_cycle(1, 1, 0, 0);
    sb_cycle(0, 1, 0, 0);
    sb_cycle(0, 0, 0, 0);
    repeat (4) sb_cycle(0, 0, 1, 0);
    sb_cycle(0, 0, 1, 0);

    // Flush with three requests outstanding, then a fresh request.
    next_pc = 32'h40;
    repeat (3) sb_cycle(1, 0, 1, 0);
    sb_cycle(0, 0, 1, 1);
    repeat (3) sb_cycle(0, 1, 1, 0);
    sb_cycle(1, 0, 1, 0);
    sb_cycle(0, 1, 1, 0);
    sb_cycle(0, 0, 1, 0);

    // Back-to-back streaming across pointer wrap.
    do_reset();
    next_pc = 32'h1000;
    sb_cycle(1, 0, 1, 0);
    repeat (9) sb_cycle(1, 1, 1, 0);
    sb_cycle(0, 1, 1, 0);
    sb_cycle(0, 0, 1, 0);
    chk("wrap_order", o_order, 64'd10);

    // Reset with two filled entries and one outstanding.
    sb_cycle(1, 0, 0, 0);
    sb_cycle(1, 1, 0, 0);
    sb_cycle(1, 1, 0, 0);
    chk("pre_rst_count", 64'(o_count), 64'd3);
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    chk("mid_rst_count", 64'(o_count), 0);
    chk("mid_rst_valid", 64'(o_valid), 0);
    chk("mid_rst_order", o_order, 0);
    chk("mid_rst_req_ok", 64'(o_req_ok), 1);
    chk("mid_rst_stall", 64'(o_imem_stall), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
